// File: rtl/hack_cpu_pkg.sv
// Shared types and constants for the hack_cpu core: FSM state codes, IR field
// positions and common comp encodings.
package hack_cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam int IR_TYPE    = 15;
    localparam int IR_ABIT    = 12;
    localparam int IR_COMP_HI = 11;
    localparam int IR_DEST_A  = 5;
    localparam int IR_DEST_D  = 4;
    localparam int IR_DEST_M  = 3;
    localparam int IR_JMP_LT  = 2;
    localparam int IR_JMP_EQ  = 1;
    localparam int IR_JMP_GT  = 0;

    localparam logic [5:0] COMP_D      = 6'b001100;
    localparam logic [5:0] COMP_A      = 6'b110000;
    localparam logic [5:0] COMP_DPLUS1 = 6'b011111;

    localparam logic [2:0] JMP_ALWAYS  = 3'b111;

endpackage

// File: rtl/hack_cpu_if.sv
// Instruction-fetch handshake and data-memory bus between the hack_cpu core
// (master) and its memories (slave).
interface hack_cpu_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [14:0] pc;
    logic [15:0] in_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;

    modport master (
        input  instr, instr_valid, in_m,
        output instr_ready, pc, out_m, write_m, address_m
    );

    modport slave (
        output instr, instr_valid, in_m,
        input  instr_ready, pc, out_m, write_m, address_m
    );
endinterface

// File: rtl/alu.sv
// Hack ALU: optional zero/negate of each operand, add or and, optional negate
// of the result; zr/ng flag a zero or negative result.
module alu (
    output logic [15:0] out,
    output logic        zr,
    output logic        ng,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
    assign zr    = (out == 16'h0000);
    assign ng    = out[15];
endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU core: FETCH latches an instruction, EXEC drives the alu
// and commits A/D/PC. Define HACK_CPU_HALT_EN to build self-loop halt detection.
module hack_cpu
    import hack_cpu_pkg::*;
#(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        reset,
    hack_cpu_if.master  bus,
    output logic [15:0] a_out,
    output logic [15:0] d_out,
    output logic        halted
);
    state_t      state, state_next;
    logic [15:0] a_reg, d_reg, ir;
    logic [14:0] pc_reg, pc_inc, pc_next;
    logic        accept, commit, ready, wr;
    logic        halt_q;
    logic        is_c, take_jump;
    logic [15:0] alu_y, alu_out;
    logic        alu_zr, alu_ng;
    logic        unused_ir_bits;

    assign is_c           = ir[IR_TYPE];
    assign alu_y          = ir[IR_ABIT] ? bus.in_m : a_reg;
    assign unused_ir_bits = ^ir[14:13];

    alu u_alu (alu_out, alu_zr, alu_ng, d_reg, alu_y,
               ir[IR_COMP_HI], ir[IR_COMP_HI-1], ir[IR_COMP_HI-2],
               ir[IR_COMP_HI-3], ir[IR_COMP_HI-4], ir[IR_COMP_HI-5]);

    assign take_jump = (ir[IR_JMP_LT] & alu_ng) |
                       (ir[IR_JMP_EQ] & alu_zr) |
                       (ir[IR_JMP_GT] & ~alu_ng & ~alu_zr);
    assign pc_inc    = pc_reg + 15'd1;
    // Jump target is the pre-commit A, even when the same instruction rewrites A.
    assign pc_next   = (is_c && take_jump) ? a_reg[14:0] : pc_inc;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next = state;
        ready      = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        wr         = 1'b0;
        case (state)
            FETCH: begin
                if (!halt_q) begin
                    ready = 1'b1;
                    if (bus.instr_valid) begin
                        accept     = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                commit     = 1'b1;
                wr         = is_c & ir[IR_DEST_M];
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_reg <= RESET_PC;
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            ir     <= 16'h0000;
        end else begin
            if (accept) ir <= bus.instr;
            if (commit) begin
                pc_reg <= pc_next;
                if (!is_c)               a_reg <= ir;
                else if (ir[IR_DEST_A])  a_reg <= alu_out;
                if (is_c && ir[IR_DEST_D]) d_reg <= alu_out;
            end
        end
    end

`ifdef HACK_CPU_HALT_EN
    always_ff @(posedge clk) begin
        if (reset)
            halt_q <= 1'b0;
        else if (commit && is_c && ir[2:0] == JMP_ALWAYS && a_reg[14:0] == pc_reg)
            halt_q <= 1'b1;
    end
`else
    assign halt_q = 1'b0;
`endif

    assign bus.instr_ready = ready;
    assign bus.pc          = pc_reg;
    assign bus.write_m     = wr;
    assign bus.out_m       = alu_out;
    assign bus.address_m   = a_reg[14:0];
    assign a_out           = a_reg;
    assign d_out           = d_reg;
    assign halted          = halt_q;
endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed test-plan steps plus random
// instructions checked against an instruction-level reference model.
module tb_hack_cpu;
    import hack_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_out, d_out;
    logic        halted;
    hack_cpu_if  bus();

    logic [15:0] tb_mem    [0:32767];
    logic [15:0] model_mem [0:32767];

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic        m_halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, COMP_D, COMP_A,
                               6'b001101, 6'b110001, 6'b001111, 6'b110011,
                               COMP_DPLUS1, 6'b110111, 6'b001110, 6'b110010,
                               6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    hack_cpu #(.RESET_PC(15'd0)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .a_out  (a_out),
        .d_out  (d_out),
        .halted (halted)
    );

    assign bus.in_m = tb_mem[bus.address_m];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hack comp mnemonics: 0,1,-1,D,A,!D,!A,-D,-A,D+1,A+1,D-1,A-1,D+A,D-A,A-D,D&A,D|A
    function automatic logic [15:0] comp_value(input logic [5:0] c, input logic [15:0] d,
                                               input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - d;
            6'b110011: return 16'd0 - y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic model_reset();
        m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0; m_halt = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_pc"}, {1'b0, bus.pc}, {1'b0, m_pc});
        check({tag, "_a"}, a_out, m_a);
        check({tag, "_d"}, d_out, m_d);
        check({tag, "_halted"}, {15'd0, halted}, {15'd0, m_halt});
    endtask

    // Called just after a rising edge with the core in FETCH; returns just after the commit edge.
    task automatic run_instr(input logic [15:0] ins);
        logic        exp_wr, taken, wr_pend;
        logic [15:0] cv, y, n_a, n_d, data_pend;
        logic [14:0] n_pc, addr_pend;
        if (!ins[15]) begin
            exp_wr = 1'b0; cv = 16'd0;
            n_a = ins; n_d = m_d; n_pc = m_pc + 15'd1;
        end else begin
            y      = ins[12] ? model_mem[m_a[14:0]] : m_a;
            cv     = comp_value(ins[11:6], m_d, y);
            exp_wr = ins[3];
            taken  = (ins[2] && $signed(cv) < 0) || (ins[1] && cv == 16'd0) ||
                     (ins[0] && $signed(cv) > 0);
            n_a    = ins[5] ? cv : m_a;
            n_d    = ins[4] ? cv : m_d;
            n_pc   = taken ? m_a[14:0] : m_pc + 15'd1;
`ifdef HACK_CPU_HALT_EN
            if (ins[2:0] == 3'b111 && m_a[14:0] == m_pc) m_halt = 1'b1;
`endif
        end
        bus.instr = ins; bus.instr_valid = 1'b1;
        check("ready_fetch", {15'd0, bus.instr_ready}, 16'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.instr = 16'($urandom);
        check("ready_exec", {15'd0, bus.instr_ready}, 16'd0);
        check("write_m_exec", {15'd0, bus.write_m}, {15'd0, exp_wr});
        check("address_m_exec", {1'b0, bus.address_m}, {1'b0, m_a[14:0]});
        if (exp_wr) check("out_m_exec", bus.out_m, cv);
        wr_pend = bus.write_m; addr_pend = bus.address_m; data_pend = bus.out_m;
        @(posedge clk); #1;
        if (wr_pend) tb_mem[addr_pend] = data_pend;
        if (exp_wr)  model_mem[m_a[14:0]] = cv;
        m_a = n_a; m_d = n_d; m_pc = n_pc;
        check("write_m_after", {15'd0, bus.write_m}, 16'd0);
        check_regs("commit");
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("stall_ready", {15'd0, bus.instr_ready}, {15'd0, ~m_halt});
            check("stall_write_m", {15'd0, bus.write_m}, 16'd0);
            check_regs("stall");
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("reset_ready", {15'd0, bus.instr_ready}, 16'd1);
        check("reset_write_m", {15'd0, bus.write_m}, 16'd0);
        check_regs("reset");
    endtask

    initial begin
        logic [15:0] ins;
        logic [14:0] pc_before;
        for (int i = 0; i < 32768; i++) begin
            ins = 16'($urandom);
            tb_mem[i] = ins; model_mem[i] = ins;
        end
        bus.instr = 16'd0; bus.instr_valid = 1'b0;
        @(negedge clk);
        do_reset(2);

        // Load D, then reset in the middle of an M=D+1 EXEC
        run_instr(16'h0005); run_instr(16'hEC10);
        check("load_d_a", a_out, 16'd5);
        check("load_d_pc", {1'b0, bus.pc}, 16'd2);
        bus.instr = 16'hE7C8; bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        do_reset(1);

        // Memory write: D=7, @100, M=D+1
        run_instr(16'h0007); run_instr(16'hEC10); run_instr(16'h0064);
        run_instr(16'hE7C8);
        check("mem_write_value", tb_mem[100], 16'd8);

        // Conditional jump taken with D=0, not taken with D=3
        run_instr(16'h0000); run_instr(16'hEC10); run_instr(16'h0014); run_instr(16'hE302);
        check("jeq_taken_pc", {1'b0, bus.pc}, 16'd20);
        run_instr(16'h0003); run_instr(16'hEC10); run_instr(16'h0014);
        pc_before = bus.pc;
        run_instr(16'hE302);
        check("jeq_not_taken_pc", {1'b0, bus.pc}, {1'b0, pc_before + 15'd1});

        // a=1 operand: D=M
        tb_mem[16'h50] = 16'h1234; model_mem[16'h50] = 16'h1234;
        run_instr(16'h0050); run_instr(16'hFC10);
        check("d_eq_m", d_out, 16'h1234);

        idle(5);

        // PC wrap: jump to 0x7FFF, then one A-instruction
        run_instr(16'h7FFF); run_instr(16'hEA87); run_instr(16'h0005);
        check("pc_wrap", {1'b0, bus.pc}, 16'd0);

        // Random instructions with random fetch stalls
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                ins = {1'b1, 2'($urandom), 1'($urandom), comps[$urandom_range(0, 17)],
                       3'($urandom), 3'($urandom)};
                if (ins[2:0] == JMP_ALWAYS && m_a[14:0] == m_pc) ins[2:0] = 3'b000;
            end
            run_instr(ins);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Self-loop at pc=11
        do_reset(1);
        run_instr(16'h000A); run_instr(16'hEA87);
        check("halt_pc10", {1'b0, bus.pc}, 16'd10);
        run_instr(16'h000B); run_instr(16'hEA87);
        check("self_loop_pc", {1'b0, bus.pc}, 16'd11);
`ifdef HACK_CPU_HALT_EN
        check("halted_set", {15'd0, halted}, 16'd1);
        bus.instr = 16'h0001; bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("halt_ready", {15'd0, bus.instr_ready}, 16'd0);
            check("halt_write_m", {15'd0, bus.write_m}, 16'd0);
            check_regs("halt_hold");
        end
        bus.instr_valid = 1'b0;
`else
        check("halted_clear", {15'd0, halted}, 16'd0);
        run_instr(16'hEA87);
        check("loop_pc", {1'b0, bus.pc}, 16'd11);
`endif
        do_reset(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no end of sequence, expected completion");
        $fatal(1, "timeout");
    end
endmodule
